// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operand signedness decode.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // MUL is treated as signed; its low product word is the same either way.
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle on magnitudes,
// sign-corrected at the end, with a single-cycle registered result presentation.
module ex_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        stall_pipeline,
  output logic        result_valid,
  output logic [31:0] result
);

  // Handshake: an op is accepted in IDLE when start=1 and flush=0; stall_pipeline
  // holds the front end from that cycle until the result cycle, where
  // result_valid=1 for exactly one cycle and the issuing instruction leaves ID/EX.
  muldiv_state_e r_state, w_state_nxt;
  logic [4:0]    r_cnt;
  logic [31:0]   r_a, r_b, r_result;
  logic [63:0]   r_acc;
  logic [2:0]    r_f3;
  logic          r_neg, r_neg_rem;

  logic          w_sa, w_sb, w_div_zero, w_div_ovf, w_special;
  logic [31:0]   w_abs_a, w_abs_b, w_special_res;
  logic [32:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic [63:0]   w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [31:0]   w_quo, w_rem, w_final;

  assign w_sa    = is_signed_a(funct3) & operand_a[31];
  assign w_sb    = is_signed_b(funct3) & operand_b[31];
  assign w_abs_a = w_sa ? (32'd0 - operand_a) : operand_a;
  assign w_abs_b = w_sb ? (32'd0 - operand_b) : operand_b;

  assign w_div_zero = funct3[2] & (operand_b == 32'd0);
  assign w_div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero | w_div_ovf;
  // funct3[1] separates REM/REMU from DIV/DIVU among the divide ops.
  assign w_special_res = w_div_zero ? (funct3[1] ? operand_a : 32'hFFFF_FFFF)
                                    : (funct3[1] ? 32'd0 : 32'h8000_0000);

  // Multiply: r_acc = {partial high, remaining multiplier bits}.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
  assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};

  // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}.
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_nxt   = w_div_diff[32] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                      : {w_div_diff[31:0],  r_acc[30:0], 1'b1};

  assign w_acc_nxt = r_f3[2] ? w_div_nxt : w_mul_nxt;
  assign w_prod    = r_neg ? (64'd0 - w_acc_nxt) : w_acc_nxt;
  assign w_quo     = r_neg ? (32'd0 - w_acc_nxt[31:0]) : w_acc_nxt[31:0];
  assign w_rem     = r_neg_rem ? (32'd0 - w_acc_nxt[63:32]) : w_acc_nxt[63:32];

  always_comb begin
    w_final = w_prod[63:32];
    case (r_f3)
      F3_MUL:           w_final = w_prod[31:0];
      F3_DIV, F3_DIVU:  w_final = w_quo;
      F3_REM, F3_REMU:  w_final = w_rem;
      default:          w_final = w_prod[63:32];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    stall_pipeline = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !flush) begin
          stall_pipeline = 1'b1;
          w_state_nxt    = w_special ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else begin
          stall_pipeline = 1'b1;
          if (r_cnt == 5'd0) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 5'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_acc     <= 64'd0;
      r_f3      <= 3'd0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            if (w_special) begin
              r_result <= w_special_res;
            end else begin
              r_a       <= w_abs_a;
              r_b       <= w_abs_b;
              r_f3      <= funct3;
              r_neg     <= w_sa ^ w_sb;
              r_neg_rem <= w_sa;
              r_cnt     <= 5'd31;
              r_acc     <= funct3[2] ? {32'd0, w_abs_a} : {32'd0, w_abs_b};
            end
          end
        end
        BUSY: begin
          if (!flush) begin
            r_acc <= w_acc_nxt;
            if (r_cnt == 5'd0) r_result <= w_final;
            else               r_cnt    <= r_cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_valid = (r_state == DONE);
  assign result       = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: timeline-level reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        stall_pipeline, result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ex_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .stall_pipeline(stall_pipeline), .result_valid(result_valid), .result(result)
  );

  // ---------------- clock / cycle index ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_b(input string nm, input logic act, input logic exp);
    check(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return ((f3 == F3_DIV) || (f3 == F3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        ea, eb, ua, ub, p;
    logic signed [31:0] sa, sb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = a;
    sb = b;
    case (f3)
      F3_MUL:    begin p = ea * eb; return p[31:0];  end
      F3_MULH:   begin p = ea * eb; return p[63:32]; end
      F3_MULHSU: begin p = ea * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // ---------------- scoreboard / per-cycle compare ----------------
  logic [31:0] exp_q[$];
  bit          m_active = 1'b0;
  int          m_valid_cyc = 0;
  logic [31:0] m_res = 32'd0;

  always @(negedge clk) begin : cmp
    bit e_valid;
    bit e_stall;
    if (!rst_n) begin
      m_active = 1'b0;
      m_res    = 32'd0;
      exp_q.delete();
    end else begin
      e_valid = m_active && (cyc == m_valid_cyc);
      if (e_valid) m_res = exp_q.pop_front();
      e_stall = !flush && ((m_active && (cyc < m_valid_cyc)) || (!m_active && start));
      check_b("stall_pipeline", stall_pipeline, e_stall);
      check_b("result_valid", result_valid, e_valid);
      check("result", result, m_res);
      if (flush || e_valid) begin
        if (m_active && !e_valid) void'(exp_q.pop_back());
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active    = 1'b1;
        m_valid_cyc = cyc + (is_special(funct3, operand_a, operand_b) ? 1 : 33);
        exp_q.push_back(ref_op(funct3, operand_a, operand_b));
      end
    end
  end

  // ---------------- driver tasks (enter/leave just after a rising edge) ----------------
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit pin, input logic [31:0] exp_res,
                        input int exp_lat);
    int lat;
    int stalls;
    bit got;
    start = 1'b1; funct3 = f3; operand_a = a; operand_b = b;
    lat = 0; stalls = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      lat++;
      if (stall_pipeline) stalls++;
    end
    if (!got) begin
      check_b({nm, "_timeout"}, 1'b0, 1'b1);
    end else if (pin) begin
      check(nm, result, exp_res);
      check({nm, "_latency"}, lat, exp_lat);
      check({nm, "_stall_cycles"}, stalls, exp_lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    flush = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_quiet(input string nm, input int n, input logic [31:0] hold_res);
    int seen;
    seen = 0;
    start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    check({nm, "_no_valid"}, seen, 0);
    check({nm, "_result_held"}, result, hold_res);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_b("reset_stall", stall_pipeline, 1'b0);
    check_b("reset_valid", result_valid, 1'b0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7_m3",   F3_MUL,    32'd7,          32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 33);
    run_op("mulhu_m1",   F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 33);
    run_op("mulh_m1",    F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'h0000_0000, 33);
    run_op("mulhsu_m1",  F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 33);
    run_op("mul_m1",     F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'h0000_0001, 33);
    run_op("div_m7_2",   F3_DIV,    32'hFFFF_FFF9,  32'd2,         1, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   F3_REM,    32'hFFFF_FFF9,  32'd2,         1, 32'hFFFF_FFFF, 33);
    run_op("divu_100_7", F3_DIVU,   32'd100,        32'd7,         1, 32'd14,        33);
    run_op("remu_100_7", F3_REMU,   32'd100,        32'd7,         1, 32'd2,         33);
    run_op("divu_5_0",   F3_DIVU,   32'd5,          32'd0,         1, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0",   F3_REMU,   32'd5,          32'd0,         1, 32'd5,         1);
    run_op("div_ovf",    F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h8000_0000, 1);
    run_op("rem_ovf",    F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1, 32'd0,         1);
    run_op("remu_last",  F3_REMU,   32'd100,        32'd7,         1, 32'd2,         33);
    expect_quiet("start_dropped_after_done", 35, 32'd2);

    // Flush in the middle of a multiply, then a new op the next cycle.
    start = 1'b1; funct3 = F3_MULHU; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    check_b("flush10_stall", stall_pipeline, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    run_op("divu_after_flush", F3_DIVU, 32'd1000, 32'd10, 1, 32'd100, 33);

    // Flush on the last busy cycle suppresses the result.
    start = 1'b1; funct3 = F3_MUL; operand_a = 32'd5; operand_b = 32'd6;
    repeat (32) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    check_b("flush32_stall", stall_pipeline, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    expect_quiet("flush_last_busy", 4, 32'd100);

    // Asynchronous reset between edges in the middle of an operation.
    start = 1'b1; funct3 = F3_MUL; operand_a = 32'd9; operand_b = 32'd9;
    repeat (5) @(posedge clk);
    #4;
    rst_n = 1'b0; start = 1'b0;
    #2;
    check_b("async_rst_stall", stall_pipeline, 1'b0);
    check_b("async_rst_valid", result_valid, 1'b0);
    check("async_rst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("mul_3_4", F3_MUL, 32'd3, 32'd4, 1, 32'd12, 33);

    // Randomized operations, some back-to-back, checked by the per-cycle model.
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op("random_op", f3, a, b, 0, 32'd0, 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
